// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: FSM encoding and default sizing.
package inst_rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH    = 4096;
    localparam int          DEFAULT_ADDR_W   = 12;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Little-endian byte-to-word assembler; emits a word strobe on the 4th byte or on the last byte.
module byte_packer
    import inst_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0] byteCnt_q, byteCnt_d;
    logic [7:0] bytes_q [3];
    logic [7:0] bytes_d [3];

    // The incoming byte is merged combinationally so the word is written in the accepting cycle.
    always_comb begin
        byteCnt_d    = byteCnt_q;
        bytes_d      = bytes_q;
        word_valid_o = 1'b0;
        word_o       = 32'h0;
        if (byte_valid_i) begin
            word_valid_o = last_i || (byteCnt_q == 2'd3);
            case (byteCnt_q)
                2'd0:    word_o = {24'h0, byte_i};
                2'd1:    word_o = {16'h0, byte_i, bytes_q[0]};
                2'd2:    word_o = {8'h0, byte_i, bytes_q[1], bytes_q[0]};
                default: word_o = {byte_i, bytes_q[2], bytes_q[1], bytes_q[0]};
            endcase
            if (word_valid_o) begin
                byteCnt_d = 2'd0;
            end else begin
                byteCnt_d = byteCnt_q + 2'd1;
                case (byteCnt_q)
                    2'd0:    bytes_d[0] = byte_i;
                    2'd1:    bytes_d[1] = byte_i;
                    2'd2:    bytes_d[2] = byte_i;
                    default: ;
                endcase
            end
        end
        if (clear_i) begin
            byteCnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byteCnt_q <= 2'd0;
        end else begin
            byteCnt_q <= byteCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        bytes_q <= bytes_d;
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with combinational fetch port and a byte-stream loader that holds the core in reset.
// Optional: define INST_ROM_CHECKSUM_EN to add checksum_o, the running sum of all words written.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter int          ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              loading_o,
    output logic              cpu_rst_o,
    output logic [ADDR_W:0]   load_words_o,
    output logic              overflow_o
`ifdef INST_ROM_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    loader_state_e   state_q, state_d;
    logic [ADDR_W:0] wordCnt_q, wordCnt_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     mem_q [DEPTH];

    logic            byteAccept;
    logic            startLoad;
    logic            memWrite;
    logic            wordValid;
    logic [31:0]     packedWord;
    logic [ADDR_W-1:0] readIdx;
    logic            addrOutOfRange;
    logic            unusedAddrBits;

    // Derived from the state register directly so the packer path does not loop through load_ready_o.
    assign byteAccept = load_valid_i && (state_q == LOAD);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (startLoad),
        .byte_valid_i (byteAccept),
        .byte_i       (load_byte_i),
        .last_i       (load_last_i),
        .word_valid_o (wordValid),
        .word_o       (packedWord)
    );

    always_comb begin
        state_d      = state_q;
        wordCnt_d    = wordCnt_q;
        overflow_d   = overflow_q;
        load_ready_o = 1'b0;
        loading_o    = 1'b1;
        cpu_rst_o    = 1'b1;
        startLoad    = 1'b0;
        memWrite     = 1'b0;
        case (state_q)
            IDLE: begin
                loading_o = 1'b0;
                cpu_rst_o = 1'b0;
                if (load_start_i) begin
                    startLoad  = 1'b1;
                    state_d    = LOAD;
                    wordCnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                load_ready_o = 1'b1;
                // Once the array is full further words are dropped but the stream is still drained.
                if (wordValid) begin
                    if (wordCnt_q == DEPTH_CNT) begin
                        overflow_d = 1'b1;
                    end else begin
                        memWrite  = 1'b1;
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
                if (byteAccept && load_last_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            cpu_rst_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wordCnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wordCnt_q  <= wordCnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && memWrite) begin
            mem_q[wordCnt_q[ADDR_W-1:0]] <= packedWord;
        end
    end

    assign load_words_o = wordCnt_q;
    assign overflow_o   = overflow_q;

    assign readIdx        = inst_addr_i[ADDR_W+1:2];
    assign addrOutOfRange = ((inst_addr_i >> (ADDR_W + 2)) != 32'd0)
                            || ({1'b0, readIdx} >= DEPTH_CNT);
    assign unusedAddrBits = ^inst_addr_i[1:0];

    // The core must never fetch a half-written image, so reads are masked while loading.
    assign inst_o = ((state_q != IDLE) || addrOutOfRange) ? NOP_WORD : mem_q[readIdx];

`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 32'h0;
        end else if (startLoad) begin
            checksum_q <= 32'h0;
        end else if (memWrite) begin
            checksum_q <= checksum_q + packedWord;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction memory that feeds the core's fetch path: word-addressed storage with a combinational read port driven by the core's instruction address.
- Also contains a byte-stream loader FSM. It fills the memory from an external byte source (UART/JTAG shim) and holds the core in reset while a load is in progress.
- Sits directly upstream of the core top: `inst_addr_i` ← core `inst_addr_o`; `inst_o` → core `inst_i`.

Parameters:
- DEPTH, 4096, number of 32-bit words stored.
- ADDR_W, 12, word-index width; must equal log2(DEPTH).
- NOP_WORD, 32'h0000_0013, value returned for out-of-range reads and during a load.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- inst_addr_i  in  32  byte address from core PC
- inst_o  out  32  instruction word (combinational)
- load_start_i  in  1  pulse; begins a load when idle
- load_valid_i  in  1  load byte valid
- load_byte_i  in  8  load byte data
- load_last_i  in  1  qualifies the final byte of the image
- load_ready_o  out  1  loader accepts a byte this cycle
- loading_o  out  1  FSM is not IDLE
- cpu_rst_o  out  1  reset request to the core top
- load_words_o  out  ADDR_W+1  number of words written in the last/current load
- overflow_o  out  1  image exceeded DEPTH words

Behaviour:
- One clock, `clk`; `rst` is synchronous, active-high. The memory array is not reset.
- Reset values:
  - FSM = IDLE
  - `load_ready_o` = 0, `loading_o` = 0
  - `cpu_rst_o` = 1 during reset; 0 in the first cycle after `rst` deasserts
  - `load_words_o` = 0, `overflow_o` = 0
  - byte counter = 0, word counter = 0
- Read port:
  - Index = `inst_addr_i[ADDR_W+1:2]`; bits [1:0] are ignored.
  - If `inst_addr_i[31:ADDR_W+2]` != 0, or the FSM is not IDLE, `inst_o` = NOP_WORD.
  - Otherwise `inst_o` = mem[index], with zero latency.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `load_ready_o` = 0, `cpu_rst_o` = 0.
  - On `load_start_i` = 1: go to LOAD; clear byte counter, word counter and `overflow_o`.
- LOAD:
  - `load_ready_o` = 1, `cpu_rst_o` = 1.
  - A byte is accepted when `load_valid_i` && `load_ready_o`.
  - Packing is little-endian: byte k of a word goes to bits [8k+7:8k]; the byte counter counts 0..3.
  - On the 4th byte, write the word to mem[word counter] and increment the word counter.
  - `load_start_i` is ignored while in LOAD.
- Last byte (accepted with `load_last_i` = 1):
  - Write any partial word, with the remaining upper bytes zero-padded.
  - Go to DONE.
  - A last byte that completes a word exactly produces exactly one write, not two.
- Overflow:
  - A word write when the word counter == DEPTH is dropped; the memory is not modified.
  - `overflow_o` is set and stays set until the next `load_start_i`.
  - Bytes continue to be accepted until `load_last_i`.
  - The word counter saturates at DEPTH.
- DONE:
  - Lasts one cycle; `cpu_rst_o` = 1, `load_ready_o` = 0.
  - Then go to IDLE, where `cpu_rst_o` drops.
- `load_words_o` = word counter, updated in the same cycle as each write; it holds after the load.
- `rst` during LOAD: FSM returns to IDLE and counters clear. Memory keeps the words already written; the partial word is discarded.
- A `load_start_i` coincident with `rst` is ignored.

Optional Feature:
- Macro `INST_ROM_CHECKSUM_EN`.
- Defined:
  - Adds output port `checksum_o` [31:0], a mod-2^32 sum of every word written (padded words included, dropped overflow words excluded).
  - Cleared to 0 on reset and on `load_start_i` accepted in IDLE.
  - Updated in the same cycle as the memory write.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2)
  - NOP_WORD constant
  - the default DEPTH/ADDR_W
- One natural sub-module, `byte_packer`:
  - Does byte counting, little-endian assembly, zero-padding on last, and generates the word-valid strobe.
  - Top level keeps the FSM, word counter, memory array, read mux and checksum.

Test Plan:
- Reset, then read `inst_addr_i` = 0x0 → `inst_o` = mem[0] (preloaded by backdoor); read 0x0001_0000 → 0x0000_0013; `cpu_rst_o` = 0.
- Start pulse, then bytes 13 00 00 00 93 00 10 00 with last on the final byte → mem[0] = 0x00000013, mem[1] = 0x00100093, `load_words_o` = 2. `cpu_rst_o` is high from LOAD entry through DONE and low one cycle after DONE.
- Partial image of bytes AA BB with last → mem[0] = 0x0000BBAA, `load_words_o` = 1.
- `load_valid_i` toggling 1/0 every cycle during LOAD → same memory contents as back-to-back; `inst_o` = NOP throughout the load.
- DEPTH = 4: stream 20 bytes → mem[0..3] written, fifth word dropped, `overflow_o` = 1, `load_words_o` = 4; the next start clears `overflow_o`.
- `rst` asserted after 6 bytes → IDLE next cycle, `loading_o` = 0, mem[0] kept, mem[1] unchanged. With `INST_ROM_CHECKSUM_EN`: loading 0x00000013 and 0x00100093 gives `checksum_o` = 0x001000A6.
